// File: rtl/pixel_block_collector.sv
// pixel_block_collector
// Collects a row-major stream of pixels into complete NUM_INTEGERS-pixel blocks.
// Two ping-pong banks let the next block fill while the finished block waits
// for the downstream converter. Pixel values pass through unmodified.
module pixel_block_collector #(
  parameter int INPUT_BITS   = 8,
  parameter int NUM_INTEGERS = 64,
  localparam int IDX_BITS    = $clog2(NUM_INTEGERS),
  localparam int BLK_BITS    = NUM_INTEGERS * INPUT_BITS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [INPUT_BITS-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [BLK_BITS-1:0]   integers,
  output logic [IDX_BITS-1:0]   in_index
);

  localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(NUM_INTEGERS - 1);
  localparam logic [IDX_BITS-1:0] ONE_IDX  = IDX_BITS'(1);

  // Bank storage and control state
  logic [BLK_BITS-1:0] bank0_q;
  logic [BLK_BITS-1:0] bank1_q;
  logic [1:0]          full_q;
  logic [1:0]          full_d;
  logic                wb_q;
  logic                wb_d;
  logic                rb_q;
  logic                rb_d;
  logic [IDX_BITS-1:0] idx_q;
  logic [IDX_BITS-1:0] idx_d;

  // Handshake qualifiers
  logic                accept_s;
  logic                release_s;
  logic                wr0_s;
  logic                wr1_s;

  // Outputs are decoded purely from registered flags and pointers, so neither
  // in_ready nor out_valid has any combinational path from the stream inputs.
  assign in_ready  = ~full_q[wb_q];
  assign out_valid = full_q[rb_q];
  assign integers  = rb_q ? bank1_q : bank0_q;
  assign in_index  = idx_q;

  // A handshake in a clear cycle is ignored, so clear gates both qualifiers.
  assign accept_s  = in_valid & in_ready & ~clear;
  assign release_s = out_valid & out_ready & ~clear;
  assign wr0_s     = accept_s & ~wb_q;
  assign wr1_s     = accept_s & wb_q;

  // Next-state decode for fill flags, bank pointers and the pixel index.
  always_comb begin
    full_d = full_q;
    wb_d   = wb_q;
    rb_d   = rb_q;
    idx_d  = idx_q;
    if (clear) begin
      full_d = 2'b00;
      wb_d   = 1'b0;
      rb_d   = 1'b0;
      idx_d  = {IDX_BITS{1'b0}};
    end else begin
      // Release and completion always target different banks (one needs the
      // presented bank full, the other needs the fill bank empty), so both
      // updates can land in the same cycle without conflict.
      if (release_s) begin
        full_d[rb_q] = 1'b0;
        rb_d         = ~rb_q;
      end else begin
        rb_d = rb_q;
      end
      if (accept_s) begin
        // NUM_INTEGERS is a power of two, so the index wraps to zero naturally.
        idx_d = idx_q + ONE_IDX;
        if (idx_q == LAST_IDX) begin
          full_d[wb_q] = 1'b1;
          wb_d         = ~wb_q;
        end else begin
          wb_d = wb_q;
        end
      end else begin
        idx_d = idx_q;
      end
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= 2'b00;
      wb_q   <= 1'b0;
      rb_q   <= 1'b0;
      idx_q  <= {IDX_BITS{1'b0}};
    end else begin
      full_q <= full_d;
      wb_q   <= wb_d;
      rb_q   <= rb_d;
      idx_q  <= idx_d;
    end
  end

  // Pixel storage: the accepted pixel lands in the fill bank at the current index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank0_q <= {BLK_BITS{1'b0}};
      bank1_q <= {BLK_BITS{1'b0}};
    end else begin
      if (wr0_s) begin
        bank0_q[idx_q*INPUT_BITS +: INPUT_BITS] <= in_data;
      end
      if (wr1_s) begin
        bank1_q[idx_q*INPUT_BITS +: INPUT_BITS] <= in_data;
      end
    end
  end

endmodule

// File: tb/tb_pixel_block_collector.sv
// Self-checking bench for pixel_block_collector: a table of hand-derived
// vectors, directed multi-cycle sequences, and randomized throttling checked
// against a queue-of-blocks reference model.
module tb_pixel_block_collector;

  localparam int W  = 8;
  localparam int N  = 64;
  localparam int IW = 6;
  localparam int BW = N * W;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clear;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [BW-1:0] integers;
  logic [IW-1:0] in_index;

  int nvec = 0;
  int nerr = 0;

  // Reference model: completed blocks in presentation order plus the partial block.
  logic [BW-1:0] mq[$];
  logic [BW-1:0] part;
  int            pcnt;
  bit            acc_last;
  bit            rel_last;

  typedef struct {
    logic         v;
    logic [W-1:0] d;
    logic         r;
    logic         c;
    logic         eov;
    logic         erdy;
    logic [IW-1:0] eidx;
  } vec_t;

  vec_t tbl[8];

  pixel_block_collector #(.INPUT_BITS(W), .NUM_INTEGERS(N)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .integers(integers), .in_index(in_index)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    part = '0;
    pcnt = 0;
  endtask

  task automatic check_model();
    chk("out_valid", BW'(out_valid), BW'(mq.size() > 0));
    chk("in_ready", BW'(in_ready), BW'(mq.size() < 2));
    chk("in_index", BW'(in_index), BW'(pcnt));
    if (mq.size() > 0) chk("integers", integers, mq[0]);
  endtask

  // One clock cycle: drive inputs, advance the model, compare all outputs.
  task automatic cycle(input logic v, input logic [W-1:0] d, input logic r, input logic c);
    bit a;
    bit rl;
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    clear     = c;
    a  = v && (mq.size() < 2) && !c;
    rl = r && (mq.size() > 0) && !c;
    @(posedge clk);
    #1;
    if (c) begin
      mq.delete();
      pcnt = 0;
    end else begin
      if (rl) mq.delete(0);
      if (a) begin
        part[pcnt*W +: W] = d;
        pcnt++;
        if (pcnt == N) begin
          mq.push_back(part);
          pcnt = 0;
        end
      end
    end
    acc_last = a;
    rel_last = rl;
    check_model();
  endtask

  initial begin
    logic [BW-1:0] exp0;
    logic [BW-1:0] exp1;
    logic [BW-1:0] a5blk;
    logic [BW-1:0] seen;
    int lowcnt;
    int pc;
    int p[3];
    int nblk;
    int pops;
    int cyc;

    tbl[0] = '{1'b1, 8'd11, 1'b0, 1'b0, 1'b0, 1'b1, 6'd1};
    tbl[1] = '{1'b0, 8'd22, 1'b0, 1'b0, 1'b0, 1'b1, 6'd1};
    tbl[2] = '{1'b1, 8'd22, 1'b0, 1'b0, 1'b0, 1'b1, 6'd2};
    tbl[3] = '{1'b1, 8'd33, 1'b0, 1'b1, 1'b0, 1'b1, 6'd0};
    tbl[4] = '{1'b1, 8'd44, 1'b0, 1'b0, 1'b0, 1'b1, 6'd1};
    tbl[5] = '{1'b0, 8'd55, 1'b1, 1'b0, 1'b0, 1'b1, 6'd1};
    tbl[6] = '{1'b0, 8'd66, 1'b0, 1'b1, 1'b0, 1'b1, 6'd0};
    tbl[7] = '{1'b1, 8'd77, 1'b1, 1'b0, 1'b0, 1'b1, 6'd1};

    for (int k = 0; k < N; k++) begin
      exp0[k*W +: W] = W'(k);
      exp1[k*W +: W] = W'(k + N);
      a5blk[k*W +: W] = 8'hA5;
    end

    // Reset
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #5 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_out_valid", BW'(out_valid), BW'(0));
    chk("rst_in_ready", BW'(in_ready), BW'(1));
    chk("rst_in_index", BW'(in_index), BW'(0));
    chk("rst_integers", integers, '0);

    // Stream 0..63 with out_ready high
    for (int i = 0; i < N; i++) cycle(1'b1, W'(i), 1'b1, 1'b0);
    chk("blk_out_valid", BW'(out_valid), BW'(1));
    chk("blk_first_px", BW'(integers[7:0]), BW'(8'h00));
    chk("blk_last_px", BW'(integers[511:504]), BW'(8'h3F));
    chk("blk_index_wrap", BW'(in_index), BW'(0));
    cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // Table-driven vectors from a clean state
    for (int i = 0; i < 8; i++) begin
      cycle(tbl[i].v, tbl[i].d, tbl[i].r, tbl[i].c);
      chk("tbl_out_valid", BW'(out_valid), BW'(tbl[i].eov));
      chk("tbl_in_ready", BW'(in_ready), BW'(tbl[i].erdy));
      chk("tbl_in_index", BW'(in_index), BW'(tbl[i].eidx));
    end

    // Two-block backpressure stall
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    for (int k = 0; k < 2*N; k++) cycle(1'b1, W'(k), 1'b0, 1'b0);
    chk("stall_in_ready", BW'(in_ready), BW'(0));
    repeat (4) cycle(1'b1, 8'hEE, 1'b0, 1'b0);
    chk("stall_hold_blk0", integers, exp0);
    chk("stall_in_ready2", BW'(in_ready), BW'(0));
    cycle(1'b1, 8'hEE, 1'b1, 1'b0);
    chk("stall_blk1", integers, exp1);
    chk("stall_ready_back", BW'(in_ready), BW'(1));
    cycle(1'b1, 8'hEE, 1'b0, 1'b0);

    // Continuous three-block stream
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    lowcnt = 0; pc = 0;
    for (int i = 0; i < 3*N; i++) begin
      if (!in_ready) lowcnt++;
      cycle(1'b1, W'($urandom), 1'b1, 1'b0);
      if (out_valid) begin
        if (pc < 3) p[pc] = i;
        pc++;
      end
    end
    chk("cont_ready_low", BW'(lowcnt), BW'(0));
    chk("cont_pulses", BW'(pc), BW'(3));
    chk("cont_gap1", BW'(p[1] - p[0]), BW'(N));
    chk("cont_gap2", BW'(p[2] - p[1]), BW'(N));
    cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // Clear mid-block then one block of 0xA5
    for (int i = 0; i < 30; i++) cycle(1'b1, W'(i + 1), 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b1);
    nblk = 0; seen = '0;
    for (int i = 0; i < N + 4; i++) begin
      cycle(i < N, 8'hA5, 1'b1, 1'b0);
      if (out_valid) begin
        nblk++;
        seen = integers;
      end
    end
    chk("clear_one_block", BW'(nblk), BW'(1));
    chk("clear_block_a5", seen, a5blk);

    // Asynchronous reset while block 0 is presented and block 1 half full
    for (int i = 0; i < N + N/2; i++) cycle(1'b1, W'($urandom), 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", BW'(out_valid), BW'(0));
    chk("arst_in_index", BW'(in_index), BW'(0));
    chk("arst_in_ready", BW'(in_ready), BW'(1));
    model_reset();
    #1 rst_n = 1'b1;
    for (int i = 0; i < N; i++) cycle(1'b1, W'($urandom), 1'b0, 1'b0);
    chk("arst_next_blk", BW'(out_valid), BW'(1));
    cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // Randomized throttling over 50 blocks
    pops = 0; cyc = 0;
    while (pops < 50 && cyc < 20000) begin
      cycle(($urandom % 4) != 0, W'($urandom), ($urandom % 3) != 0, 1'b0);
      if (rel_last) pops++;
      cyc++;
    end
    chk("rand_blocks", BW'(pops), BW'(50));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
